// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset vector, opcodes, queue entry and FSM state.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes, also consumed by the control unit
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_U    = 7'b0010111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_FLW  = 7'b0000111;
  localparam logic [6:0] OP_FSW  = 7'b0100111;
  localparam logic [6:0] OP_FCAL = 7'b1010011;
  localparam logic [6:0] OP_CSR  = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction queue between fetch and decode; push and pop may coincide.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A push into a full queue is legal only when the head leaves in the same cycle
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // Pointer and occupancy tracking; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; cleared on reset so decode sees a zero word
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, stale-response dropping on redirect,
// and a two-entry queue feeding decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [6:0]  id_op,
  output logic [2:0]  id_funct3
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 3);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(MAX_OUTST);
  localparam logic [CW-1:0] ONE        = CW'(1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW:0]   credit_used;
  logic          req_hs;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_wdata;
  fetch_entry_t  fifo_head;
  logic [1:0]    fifo_count;
  logic          fifo_empty;

  assign credit_used  = {1'b0, outst_q} + {{(CW-1){1'b0}}, fifo_count};
  assign im_req_valid = !rst && (state_q != ST_RESET) && !redirect_valid &&
                        (credit_used < CREDIT_MAX);
  assign im_req_addr  = fetch_pc_q;
  assign req_hs       = im_req_valid && im_req_ready;

  // Responses are dropped while stale ones are draining and in the redirect cycle itself
  assign fifo_push  = im_rsp_valid && !redirect_valid && (drop_q == '0);
  assign fifo_wdata = '{pc: rsp_pc_q, inst: im_rsp_data};

  assign id_valid  = !rst && !fifo_empty && !redirect_valid;
  assign fifo_pop  = id_valid && id_ready;
  assign id_inst   = fifo_head.inst;
  assign id_pc     = fifo_head.pc;
  assign id_op     = fifo_head.inst[6:0];
  assign id_funct3 = fifo_head.inst[14:12];

  // Next-state for credit, drop accounting, PCs and FSM.
  // outstanding counts every in-flight request, stale or not, so on a redirect the
  // whole post-update in-flight count becomes the drop count; this also yields the
  // accumulation behaviour when a redirect lands during an ongoing flush.
  always_comb begin
    outst_d = outst_q;
    if (req_hs && !im_rsp_valid)      outst_d = outst_q + ONE;
    else if (!req_hs && im_rsp_valid) outst_d = outst_q - ONE;

    drop_d = drop_q;
    if (redirect_valid)                       drop_d = outst_d;
    else if (im_rsp_valid && drop_q != '0)    drop_d = drop_q - ONE;

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = word_align(redirect_pc);
    else if (req_hs)     fetch_pc_d = fetch_pc_q + 32'd4;

    rsp_pc_d = rsp_pc_q;
    if (redirect_valid)  rsp_pc_d = word_align(redirect_pc);
    else if (fifo_push)  rsp_pc_d = rsp_pc_q + 32'd4;

    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      default:  state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
    endcase
  end

  // Fetch control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect stimulus against a queue-level model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, im_req_valid, im_req_ready, im_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] im_req_addr, im_rsp_data, redirect_pc, id_inst, id_pc;
  logic [6:0]  id_op;
  logic [2:0]  id_funct3;

  logic        rst2, vld2, rdy2, rsp2, redir2, idv2, idr2;
  logic [31:0] addr2, data2, rpc2, inst2, pc2;
  logic [6:0]  op2;
  logic [2:0]  f32;

  fetch_unit #(.RESET_PC(RPC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
    .im_req_addr(im_req_addr), .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_op(id_op), .id_funct3(id_funct3)
  );

  fetch_unit #(.RESET_PC(RPC2), .MAX_OUTST(MAX_OUTST)) dut2 (
    .clk(clk), .rst(rst2), .im_req_valid(vld2), .im_req_ready(rdy2),
    .im_req_addr(addr2), .im_rsp_valid(rsp2), .im_rsp_data(data2),
    .redirect_valid(redir2), .redirect_pc(rpc2), .id_valid(idv2),
    .id_ready(idr2), .id_inst(inst2), .id_pc(pc2), .id_op(op2), .id_funct3(f32)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          cyc;
  } pend_t;

  pend_t       pend[$];   // requests accepted by memory, response not yet returned
  logic [31:0] fq[$];     // PCs of instructions decode should see, oldest first
  logic [31:0] exp_fetch;
  bit          rst_prev;
  int          cyc;
  bit          prev_vld, prev_acc, prev_rd, prev_rst;
  logic [31:0] prev_addr;
  int          p_ready, p_rsp, p_idr, p_redir;
  bit          ev_hs, ev_pop, ev_idv, ev_reqv;
  logic [31:0] ev_addr, ev_idpc, ev_inst;

  // Synthetic instruction memory contents
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] h;
    h = (a ^ 32'h2545_F491) * 32'h9E37_79B1;
    return h ^ (h >> 15);
  endfunction

  task automatic choose_inputs();
    im_req_ready = ($urandom_range(0, 99) < p_ready);
    if (pend.size() > 0 && pend[0].cyc < cyc && $urandom_range(0, 99) < p_rsp) begin
      im_rsp_valid = 1'b1;
      im_rsp_data  = memfn(pend[0].addr);
    end else begin
      im_rsp_valid = 1'b0;
      im_rsp_data  = $urandom;
    end
    id_ready       = ($urandom_range(0, 99) < p_idr);
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                 : ($urandom & 32'h0000_0FFF);
  endtask

  // One clock: sample and check at negedge, advance model at posedge, drive next inputs
  task automatic cycle();
    bit           hs, rsp, pop, rd, r, exp_idv;
    logic [31:0]  addr, exp_inst;
    pend_t        e;
    int           stale_n;
    fetch_state_e exp_st;
    @(negedge clk);
    r = rst; rd = redirect_valid; rsp = im_rsp_valid;
    hs = (im_req_valid === 1'b1) && im_req_ready;
    pop = (id_valid === 1'b1) && id_ready;
    addr = im_req_addr;
    ev_hs = hs; ev_addr = addr; ev_pop = pop; ev_idv = (id_valid === 1'b1);
    ev_idpc = id_pc; ev_inst = id_inst; ev_reqv = (im_req_valid === 1'b1);
    if (r) begin
      checks++;
      if (im_req_valid !== 1'b0 || id_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_outputs: req_valid=%b id_valid=%b required 0 0", im_req_valid, id_valid);
      end
    end else begin
      stale_n = 0;
      foreach (pend[i]) if (pend[i].stale) stale_n++;
      checks++;
      if (im_req_valid !== 1'b0 && (rd || pend.size() + fq.size() >= MAX_OUTST)) begin
        errors++;
        $display("FAIL req_credit: req_valid=%b with inflight=%0d queued=%0d redirect=%b required 0",
                 im_req_valid, pend.size(), fq.size(), rd);
      end
      if (im_req_valid === 1'b1) begin
        checks++;
        if (addr !== exp_fetch) begin
          errors++;
          $display("FAIL req_addr: got %h required %h", addr, exp_fetch);
        end
      end
      if (prev_vld && !prev_acc && !prev_rd && !prev_rst && !rd) begin
        checks++;
        if (im_req_valid !== 1'b1 || addr !== prev_addr) begin
          errors++;
          $display("FAIL req_hold: valid=%b addr=%h required 1 %h", im_req_valid, addr, prev_addr);
        end
      end
      exp_idv = (fq.size() > 0) && !rd;
      checks++;
      if (id_valid !== exp_idv) begin
        errors++;
        $display("FAIL id_valid: got %b required %b", id_valid, exp_idv);
      end
      if (exp_idv && id_valid === 1'b1) begin
        exp_inst = memfn(fq[0]);
        checks++;
        if (id_pc !== fq[0] || id_inst !== exp_inst || id_op !== exp_inst[6:0] ||
            id_funct3 !== exp_inst[14:12]) begin
          errors++;
          $display("FAIL id_entry: pc=%h inst=%h op=%h f3=%h required %h %h %h %h",
                   id_pc, id_inst, id_op, id_funct3, fq[0], exp_inst, exp_inst[6:0], exp_inst[14:12]);
        end
      end
      exp_st = rst_prev ? ST_RESET : ((stale_n > 0) ? ST_FLUSH : ST_RUN);
      checks++;
      if (dut.state_q !== exp_st) begin
        errors++;
        $display("FAIL fsm_state: got %0d required %0d", dut.state_q, exp_st);
      end
    end
    prev_vld = (im_req_valid === 1'b1); prev_acc = hs; prev_rd = rd; prev_rst = r; prev_addr = addr;
    @(posedge clk);
    if (r) begin
      pend.delete(); fq.delete(); exp_fetch = RPC; rst_prev = 1'b1;
    end else begin
      if (pop && fq.size() > 0) void'(fq.pop_front());
      if (rsp && pend.size() > 0) begin
        e = pend.pop_front();
        if (!e.stale && !rd) fq.push_back(e.addr);
      end
      if (hs) pend.push_back('{addr: addr, stale: rd, cyc: cyc});
      if (rd) begin
        fq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      end else if (hs) begin
        exp_fetch = exp_fetch + 32'd4;
      end
      rst_prev = 1'b0;
    end
    cyc++;
    #1;
    choose_inputs();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0; redirect_valid = 1'b0; im_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    p_ready = 100; p_rsp = 100; p_idr = 100; p_redir = 0;
    rst = 1'b1;
    repeat (2) cycle();
    #1;
    checks++; if (im_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b required 0", im_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b required 0", id_valid); end
    checks++; if (im_req_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h required %h", im_req_addr, RPC); end
    checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_word: inst=%h pc=%h required 0 0", id_inst, id_pc); end
    checks++; if (dut.state_q !== ST_RESET) begin errors++; $display("FAIL reset_state: got %0d required %0d", dut.state_q, ST_RESET); end
    rst = 1'b0; redirect_valid = 1'b0; im_rsp_valid = 1'b0;
  endtask

  task automatic test_stream();
    int          first_hs, first_idv, nh;
    logic [31:0] hs_addr[4];
    logic [31:0] first_pc, first_inst, exp0;
    first_hs = -1; first_idv = -1; nh = 0; first_pc = 'x; first_inst = 'x;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (ev_hs && nh < 4) begin hs_addr[nh] = ev_addr; nh++; end
      if (ev_hs && first_hs < 0) first_hs = c;
      if (ev_idv && first_idv < 0) begin first_idv = c; first_pc = ev_idpc; first_inst = ev_inst; end
    end
    exp0 = memfn(32'h0);
    checks++;
    if (first_hs < 0 || first_idv - first_hs != 2) begin
      errors++; $display("FAIL stream_latency: hs@%0d idv@%0d required gap 2", first_hs, first_idv);
    end
    checks++;
    if (first_pc !== 32'h0 || first_inst[6:0] !== exp0[6:0]) begin
      errors++; $display("FAIL stream_first: pc=%h op=%h required 0 %h", first_pc, first_inst[6:0], exp0[6:0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= nh || hs_addr[i] !== 32'(i * 4)) begin
        errors++; $display("FAIL stream_addr%0d: got %h required %h", i, (i < nh) ? hs_addr[i] : 32'hx, 32'(i * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic [31:0] popped[3];
    int          np;
    bit          seen;
    p_ready = 100; p_rsp = 100; p_idr = 0; p_redir = 0;
    apply_reset();
    id_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin cycle(); seen = ev_idv; end
    held = ev_inst;
    checks++; if (!seen) begin errors++; $display("FAIL bp_first_valid: id_valid=0 required 1 within 10 cycles"); end
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++;
      if (ev_inst !== held || ev_idpc !== 32'h0) begin
        errors++; $display("FAIL bp_hold: inst=%h pc=%h required %h 0", ev_inst, ev_idpc, held);
      end
    end
    checks++;
    if (ev_reqv || pend.size() != 0 || fq.size() != 2) begin
      errors++; $display("FAIL bp_credit: req_valid=%b inflight=%0d queued=%0d required 0 0 2", ev_reqv, pend.size(), fq.size());
    end
    p_idr = 100; id_ready = 1'b1; np = 0;
    for (int c = 0; c < 20 && np < 3; c++) begin
      cycle();
      if (ev_pop) begin popped[np] = ev_idpc; np++; end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= np || popped[i] !== 32'(i * 4)) begin
        errors++; $display("FAIL bp_order%0d: got %h required %h", i, (i < np) ? popped[i] : 32'hx, 32'(i * 4));
      end
    end
  endtask

  // Build two in-flight requests, then redirect; optionally a response lands in the redirect cycle
  task automatic redirect_case(input logic [31:0] target, input bit rsp_same, input string nm);
    bit popped;
    p_ready = 100; p_rsp = 0; p_idr = 100; p_redir = 0;
    apply_reset();
    for (int c = 0; c < 10 && pend.size() < 2; c++) cycle();
    checks++;
    if (pend.size() != 2) begin errors++; $display("FAIL %s_setup: inflight=%0d required 2", nm, pend.size()); end
    redirect_valid = 1'b1; redirect_pc = target;
    if (rsp_same && pend.size() > 0) begin im_rsp_valid = 1'b1; im_rsp_data = memfn(pend[0].addr); end
    else im_rsp_valid = 1'b0;
    cycle();
    #1;
    checks++;
    if (dut.state_q !== ST_FLUSH) begin errors++; $display("FAIL %s_flush: state=%0d required %0d", nm, dut.state_q, ST_FLUSH); end
    p_rsp = 100; popped = 1'b0;
    for (int c = 0; c < 30 && !popped; c++) begin
      cycle();
      if (ev_pop) begin
        popped = 1'b1;
        checks++;
        if (ev_idpc !== (target & 32'hFFFF_FFFC)) begin
          errors++; $display("FAIL %s_target: id_pc=%h required %h", nm, ev_idpc, target & 32'hFFFF_FFFC);
        end
      end
    end
    checks++;
    if (!popped || dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL %s_drain: popped=%b state=%0d required 1 %0d", nm, popped, dut.state_q, ST_RUN);
    end
  endtask

  task automatic test_redirect();
    redirect_case(32'h0000_0100, 1'b0, "redir");
  endtask

  task automatic test_redirect_rsp();
    redirect_case(32'h0000_2003, 1'b1, "redir_rsp");
  endtask

  task automatic test_reset_mid();
    p_ready = 100; p_rsp = 100; p_idr = 0; p_redir = 0;
    apply_reset();
    id_ready = 1'b0;
    for (int c = 0; c < 15 && fq.size() < 2; c++) cycle();
    checks++;
    if (fq.size() != 2) begin errors++; $display("FAIL rmid_fill: queued=%0d required 2", fq.size()); end
    rst = 1'b1;
    cycle();
    rst = 1'b0; redirect_valid = 1'b0; im_rsp_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rmid_id_valid: got %b required 0", id_valid); end
    checks++; if (im_req_addr !== RPC) begin errors++; $display("FAIL rmid_addr: got %h required %h", im_req_addr, RPC); end
    repeat (5) cycle();
  endtask

  task automatic test_random();
    int pops;
    pops = 0;
    apply_reset();
    for (int b = 0; b < 10; b++) begin
      p_ready = $urandom_range(20, 100); p_rsp = $urandom_range(20, 100);
      p_idr = $urandom_range(10, 100);   p_redir = $urandom_range(0, 6);
      for (int c = 0; c < 200; c++) begin cycle(); if (ev_pop) pops++; end
    end
    checks++;
    if (pops < 50) begin errors++; $display("FAIL random_progress: pops=%0d required >=50", pops); end
    p_redir = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] seen[3];
    logic [31:0] q2[$];
    logic [31:0] exp_a[3];
    int          n;
    bit          hs, r;
    logic [31:0] a;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    rst2 = 1'b1; rdy2 = 1'b1; idr2 = 1'b1; rsp2 = 1'b0; redir2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      hs = (vld2 === 1'b1) && rdy2; a = addr2; r = rsp2;
      if (hs) begin seen[n] = a; n++; end
      @(posedge clk);
      if (r && q2.size() > 0) void'(q2.pop_front());
      if (hs) q2.push_back(a);
      #1;
      rsp2  = (q2.size() > 0);
      data2 = (q2.size() > 0) ? memfn(q2[0]) : 32'h0;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= n || seen[i] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h required %h", i, (i < n) ? seen[i] : 32'hx, exp_a[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; im_req_ready = 1'b0; im_rsp_valid = 1'b0; im_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    rst2 = 1'b1; rdy2 = 1'b0; rsp2 = 1'b0; data2 = '0; redir2 = 1'b0; rpc2 = '0; idr2 = 1'b0;
    exp_fetch = RPC; rst_prev = 1'b1; cyc = 0;
    prev_vld = 1'b0; prev_acc = 1'b0; prev_rd = 1'b0; prev_rst = 1'b1; prev_addr = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rsp();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: MAX_OUTST, 2, credit limit on outstanding requests plus queued entries.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 im_req_valid  out  1  instruction-memory request valid.
REQ-006 im_req_ready  in  1  memory accepts request; handshake = valid & ready.
REQ-007 im_req_addr  out  32  word-aligned fetch address.
REQ-008 im_rsp_valid  in  1  response valid, in request order, no backpressure.
REQ-009 im_rsp_data  in  32  fetched instruction.
REQ-010 redirect_valid  in  1  branch/jump redirect from EX (taken branch, jal, jalr).
REQ-011 redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-012 id_valid  out  1  instruction available to decode.
REQ-013 id_ready  in  1  decode accepts; handshake = id_valid & id_ready.
REQ-014 id_inst  out  32  instruction word (head of queue).
REQ-015 id_pc  out  32  PC of id_inst.
REQ-016 id_op  out  7  id_inst[6:0], drives control-unit op input.
REQ-017 id_funct3  out  3  id_inst[14:12], drives control-unit funct3 input.

Function
REQ-018 fetch_pc register SHALL supply im_req_addr; on request handshake fetch_pc SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 im_req_valid SHALL be high only when outstanding + queue_count < MAX_OUTST and redirect_valid is low; once asserted, im_req_valid and im_req_addr SHALL hold until accepted or a redirect occurs.
REQ-020 Outstanding counter SHALL increment on request handshake, decrement on im_rsp_valid, both in the same cycle leaving it unchanged.
REQ-021 Non-discarded responses SHALL be written with their PC into a 2-entry FIFO; id_valid SHALL rise the cycle after im_rsp_valid (one-cycle latency); no combinational rsp->id path.
REQ-022 Credit rule guarantees no response arrives with the FIFO full; FIFO SHALL support simultaneous push and pop when count is 1 or 2.
REQ-023 id_valid SHALL equal FIFO not-empty and SHALL be forced low while redirect_valid is high; id_inst/id_pc SHALL be stable while id_valid & !id_ready.
REQ-024 Redirect: next cycle fetch_pc = redirect_pc, FIFO empty, drop counter = outstanding after this cycle's updates (includes a request accepted in the redirect cycle, excludes a response arriving in the redirect cycle, which is itself discarded).
REQ-025 While drop counter > 0, each im_rsp_valid SHALL decrement it and SHALL NOT be enqueued.
REQ-026 Redirect during nonzero drop counter SHALL accumulate: drop = drop - rsp_this_cycle + new_requests + live outstanding.
REQ-027 FSM: RESET -> RUN on first cycle rst low; RUN -> FLUSH on redirect_valid if drop counter becomes nonzero; FLUSH -> RUN when drop reaches 0; requests to new target SHALL issue in FLUSH subject to REQ-019.

Reset
REQ-028 While rst high: im_req_valid=0, id_valid=0, fetch_pc=RESET_PC, outstanding=0, drop=0, FIFO empty, state=RESET; im_req_addr=RESET_PC, id_inst=0, id_pc=0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight and queued state; responses arriving after reset deassertion for pre-reset requests are out of contract.

Structure
REQ-030 Shared package SHALL hold RESET_PC default, opcode constants (R/I/Load/S/B/J/Jalr/U/Lui/Flw/Fsw/Fcal/CSR) shared with the control unit, fetch-entry struct {pc[31:0], inst[31:0]}, FSM state enum.
REQ-031 One sub-module fetch_fifo (2-entry, entry struct, push/pop/count) SHALL be instantiated; all credit/drop logic stays in fetch_unit.

Verification
REQ-032 Reset release, ready=1, memory latency 1 -> requests at 0x0,0x4,...; first id_valid 2 cycles after first handshake with id_pc=0x0, id_op = inst[6:0].
REQ-033 id_ready=0 for 10 cycles -> at most 2 queued plus 0 outstanding, im_req_valid low, id_inst held constant; release -> in-order 0x0,0x4,0x8 with no loss/duplication.
REQ-034 Redirect to 0x100 with 2 requests outstanding -> both stale responses dropped, next id_pc=0x100, FSM passes FLUSH.
REQ-035 Redirect in same cycle as im_rsp_valid and request handshake -> both dropped, drop accounting returns to 0, next id_pc = target.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst pulse mid-stream with full FIFO -> next cycle id_valid=0, im_req_addr=RESET_PC.
